alu_pipe_ctrl: RTL and testbench

// Parametrised, registered successor to the combinational 32-bit ALU. Same 6-bit opcode set (ADD/SUB/ABS/NEG) plus sequential signed MUL.

---
 rtl/alu_pkg.sv | 27 ++
 rtl/alu_pipe_ctrl_if.sv | 27 ++
 rtl/alu_mul_seq.sv | 61 ++++++
 rtl/alu_pipe_ctrl.sv | 140 ++++++++++++++
 tb/tb_alu_pipe_ctrl.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcode constants, FSM encoding and saturation limits shared by the ALU pipe.
package alu_pkg;

  localparam int MAXW = 64;

  localparam logic [5:0] OP_ADD = 6'd4;
  localparam logic [5:0] OP_SUB = 6'd14;
  localparam logic [5:0] OP_ABS = 6'd8;
  localparam logic [5:0] OP_NEG = 6'd11;
  localparam logic [5:0] OP_MUL = 6'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Limits are built MAXW wide; callers slice the low w bits.
  function automatic logic [MAXW-1:0] sat_max(input int w);
    sat_max = (MAXW'(1) << (w - 1)) - MAXW'(1);
  endfunction

  function automatic logic [MAXW-1:0] sat_min(input int w);
    sat_min = MAXW'(1) << (w - 1);
  endfunction

endpackage

// File: rtl/alu_pipe_ctrl_if.sv
// rtl/alu_pipe_ctrl_if.sv - operation request and result/flags handshake between decoder, ALU and write-back.
interface alu_pipe_ctrl_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [5:0]       opcode;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             neg;
  logic             ovf;
  logic             err;

  modport master (
    output in_valid, opcode, a, b, out_ready,
    input  in_ready, out_valid, result, zero, neg, ovf, err
  );

  modport slave (
    input  in_valid, opcode, a, b, out_ready,
    output in_ready, out_valid, result, zero, neg, ovf, err
  );
endinterface

// File: rtl/alu_mul_seq.sv
// rtl/alu_mul_seq.sv - iterative shift-add multiplier on operand magnitudes, one bit per cycle.
module alu_mul_seq #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               done,
  output logic [2*WIDTH-1:0] prod
);

  localparam int CW = $clog2(WIDTH + 1);

  logic               busy_q;
  logic [CW-1:0]      cnt_q;
  logic [2*WIDTH-1:0] mcand_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [2*WIDTH-1:0] acc_d;
  logic [WIDTH-1:0]   mplier_q;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;

  // -MIN keeps the MIN bit pattern, which is the correct unsigned magnitude.
  assign mag_a = a[WIDTH-1] ? -a : a;
  assign mag_b = b[WIDTH-1] ? -b : b;

  // done fires during the last iteration and prod is the post-iteration sum,
  // so the consumer captures the full product on the same edge.
  always_comb begin
    acc_d = acc_q + (mplier_q[0] ? mcand_q : '0);
    done  = busy_q && (cnt_q == CW'(WIDTH - 1));
    prod  = acc_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q   <= 1'b0;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
    end else if (start) begin
      busy_q   <= 1'b1;
      cnt_q    <= '0;
      mcand_q  <= {{WIDTH{1'b0}}, mag_a};
      mplier_q <= mag_b;
      acc_q    <= '0;
    end else if (busy_q) begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q + CW'(1);
      if (done) begin
        busy_q <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/alu_pipe_ctrl.sv
// rtl/alu_pipe_ctrl.sv - registered ALU with valid/ready handshake, flags, optional saturation and sequential MUL.
module alu_pipe_ctrl
  import alu_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter bit SAT_EN = 1'b0
) (
  input  logic           clk,
  input  logic           reset,
  alu_pipe_ctrl_if.slave bus
);

  localparam logic [MAXW-1:0]  MAX_FULL = sat_max(WIDTH);
  localparam logic [MAXW-1:0]  MIN_FULL = sat_min(WIDTH);
  localparam logic [WIDTH-1:0] S_MAX    = MAX_FULL[WIDTH-1:0];
  localparam logic [WIDTH-1:0] S_MIN    = MIN_FULL[WIDTH-1:0];

  state_e state_q, state_d;
  logic   accept, is_mul, mul_start, mul_done;

  logic [WIDTH-1:0]   result_q;
  logic               zero_q, neg_q, ovf_q, err_q, mul_neg_q;
  logic [WIDTH-1:0]   alu_res, sat_val, nm_res, mul_res;
  logic               alu_ovf, alu_err, mul_ovf;
  logic [2*WIDTH-1:0] mul_prod, mul_signed;

  assign is_mul    = (bus.opcode == OP_MUL);
  assign mul_start = accept && is_mul;

  alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
    .clk   (clk),
    .reset (reset),
    .start (mul_start),
    .a     (bus.a),
    .b     (bus.b),
    .done  (mul_done),
    .prod  (mul_prod)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = is_mul ? ST_CALC : ST_DONE;
      ST_CALC: if (mul_done) state_d = ST_DONE;
      ST_DONE: begin
        if (accept) begin
          state_d = is_mul ? ST_CALC : ST_DONE;
        end else if (bus.out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready  = (state_q == ST_IDLE) || ((state_q == ST_DONE) && bus.out_ready);
    bus.out_valid = (state_q == ST_DONE);
    accept        = bus.in_valid && bus.in_ready;
  end

  // Single-cycle ops; sat_val is the clamp direction if the op overflows.
  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    alu_err = 1'b0;
    sat_val = S_MAX;
    case (bus.opcode)
      OP_ADD: begin
        alu_res = bus.a + bus.b;
        alu_ovf = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (alu_res[WIDTH-1] != bus.a[WIDTH-1]);
        sat_val = bus.a[WIDTH-1] ? S_MIN : S_MAX;
      end
      OP_SUB: begin
        alu_res = bus.a - bus.b;
        alu_ovf = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (alu_res[WIDTH-1] != bus.a[WIDTH-1]);
        sat_val = bus.a[WIDTH-1] ? S_MIN : S_MAX;
      end
      OP_ABS: begin
        alu_res = bus.a[WIDTH-1] ? -bus.a : bus.a;
        alu_ovf = (bus.a == S_MIN);
      end
      OP_NEG: begin
        alu_res = -bus.a;
        alu_ovf = (bus.a == S_MIN);
      end
      OP_MUL: alu_res = '0;
      default: alu_err = 1'b1;
    endcase
    nm_res = (SAT_EN && alu_ovf) ? sat_val : alu_res;
  end

  // The product fits WIDTH only if its top WIDTH+1 bits are all sign copies.
  always_comb begin
    mul_signed = mul_neg_q ? -mul_prod : mul_prod;
    mul_ovf    = !((&mul_signed[2*WIDTH-1:WIDTH-1]) || !(|mul_signed[2*WIDTH-1:WIDTH-1]));
    mul_res    = (SAT_EN && mul_ovf) ? (mul_neg_q ? S_MIN : S_MAX) : mul_signed[WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      result_q  <= '0;
      zero_q    <= 1'b0;
      neg_q     <= 1'b0;
      ovf_q     <= 1'b0;
      err_q     <= 1'b0;
      mul_neg_q <= 1'b0;
    end else if (accept) begin
      mul_neg_q <= bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
      if (!is_mul) begin
        result_q <= nm_res;
        zero_q   <= (nm_res == '0);
        neg_q    <= nm_res[WIDTH-1];
        ovf_q    <= alu_ovf;
        err_q    <= alu_err;
      end
    end else if ((state_q == ST_CALC) && mul_done) begin
      result_q <= mul_res;
      zero_q   <= (mul_res == '0);
      neg_q    <= mul_res[WIDTH-1];
      ovf_q    <= mul_ovf;
      err_q    <= 1'b0;
    end
  end

  assign bus.result = result_q;
  assign bus.zero   = zero_q;
  assign bus.neg    = neg_q;
  assign bus.ovf    = ovf_q;
  assign bus.err    = err_q;

endmodule

// File: tb/tb_alu_pipe_ctrl.sv
// tb/tb_alu_pipe_ctrl.sv - scoreboard bench running wrap and saturating ALU instances in lockstep.
module tb_alu_pipe_ctrl;
  import alu_pkg::*;

  localparam int W = 32;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  alu_pipe_ctrl_if #(.WIDTH(W)) bus0 ();
  alu_pipe_ctrl_if #(.WIDTH(W)) bus1 ();

  assign bus1.in_valid  = bus0.in_valid;
  assign bus1.opcode    = bus0.opcode;
  assign bus1.a         = bus0.a;
  assign bus1.b         = bus0.b;
  assign bus1.out_ready = bus0.out_ready;

  alu_pipe_ctrl #(.WIDTH(W), .SAT_EN(1'b0)) dut0 (.clk(clk), .reset(reset), .bus(bus0));
  alu_pipe_ctrl #(.WIDTH(W), .SAT_EN(1'b1)) dut1 (.clk(clk), .reset(reset), .bus(bus1));

  typedef struct {
    logic [W-1:0] r0;
    logic [W-1:0] r1;
    logic [3:0]   f0;
    logic [3:0]   f1;
    int           acc;
    int           lat;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   first_cyc = 0;
  bit   seen = 0;
  bit   rnd_ready = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=0x%0h exp=0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic exp_t model(input logic [5:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t   e;
    longint sa = $signed(a);
    longint sb_ = $signed(b);
    longint v;
    bit     known = 1'b1;
    bit     ov;
    case (op)
      OP_ADD: v = sa + sb_;
      OP_SUB: v = sa - sb_;
      OP_ABS: v = (sa < 0) ? -sa : sa;
      OP_NEG: v = -sa;
      OP_MUL: v = sa * sb_;
      default: begin v = 0; known = 1'b0; end
    endcase
    ov   = known && ((v > 64'sd2147483647) || (v < -64'sd2147483648));
    e.r0 = v[W-1:0];
    e.r1 = ov ? ((v > 0) ? 32'h7FFF_FFFF : 32'h8000_0000) : v[W-1:0];
    e.f0 = {(e.r0 == 0), e.r0[W-1], ov, !known};
    e.f1 = {(e.r1 == 0), e.r1[W-1], ov, !known};
    e.lat = (op == OP_MUL) ? W + 1 : 1;
    e.acc = 0;
    return e;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #2;
    if (rnd_ready) bus0.out_ready = 1'($urandom_range(0, 1));
  end

  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      if (bus0.out_valid && !seen) begin
        first_cyc = cyc;
        seen = 1'b1;
      end
      if (bus0.out_valid && bus0.out_ready) begin
        if (sb.size() == 0) begin
          chk("spurious_out", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("result_wrap", bus0.result, e.r0);
          chk("result_sat", bus1.result, e.r1);
          chk("flags_wrap", {bus0.zero, bus0.neg, bus0.ovf, bus0.err}, e.f0);
          chk("flags_sat", {bus1.zero, bus1.neg, bus1.ovf, bus1.err}, e.f1);
          chk("valid_sat", bus1.out_valid, 1);
          chk("latency", first_cyc - e.acc + 1, e.lat);
        end
        seen = 1'b0;
      end
    end
  end

  task automatic send(input logic [5:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    bit   ok = 1'b0;
    bus0.in_valid = 1'b1;
    bus0.opcode   = op;
    bus0.a        = a;
    bus0.b        = b;
    for (int t = 0; t < 300 && !ok; t++) begin
      @(negedge clk);
      if (bus0.in_ready) begin
        e = model(op, a, b);
        e.acc = cyc + 1;
        sb.push_back(e);
        ok = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    if (!ok) chk("send_timeout", 0, 1);
    bus0.in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int t = 0; t < 300 && sb.size() != 0; t++) begin
      @(posedge clk);
      #1;
    end
    chk("drain_left", sb.size(), 0);
  endtask

  task automatic check_idle(input string tag);
    @(negedge clk);
    chk({tag, "_in_ready"}, bus0.in_ready, 1);
    chk({tag, "_out_valid"}, {bus0.out_valid, bus1.out_valid}, 0);
    chk({tag, "_result"}, {bus0.result, bus1.result}, 0);
    chk({tag, "_flags"}, {bus0.zero, bus0.neg, bus0.ovf, bus0.err, bus1.zero, bus1.neg, bus1.ovf, bus1.err}, 0);
  endtask

  logic [5:0]   d_op [12] = '{OP_ADD, OP_SUB, OP_ABS, OP_NEG, OP_NEG, OP_ADD,
                              OP_SUB, OP_ADD, OP_SUB, OP_ABS, 6'd63, OP_ABS};
  logic [W-1:0] d_a  [12] = '{32'h3FAE, 32'h3FAE, 32'h3FAE, 32'h3FAE, 32'h8000_0000, 32'h7FFF_FFFF,
                              32'h0, 32'hFFFF_FFFB, 32'h8000_0000, 32'hFFFF_FFF7, 32'h1234, 32'h8000_0000};
  logic [W-1:0] d_b  [12] = '{32'hBB2, 32'hBB2, 32'h0, 32'h0, 32'h0, 32'h1,
                              32'h0, 32'hFFFF_FFF9, 32'h1, 32'h0, 32'h5678, 32'h0};
  logic [W-1:0] m_a  [5]  = '{32'h10000, 32'h0, 32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFFF};
  logic [W-1:0] m_b  [5]  = '{32'h10000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1, 32'hFFFF_FFFF};
  logic [5:0]   r_ops [6] = '{OP_ADD, OP_SUB, OP_ABS, OP_NEG, OP_MUL, 6'd40};
  logic [W-1:0] r_vals [4] = '{32'h8000_0000, 32'h7FFF_FFFF, 32'h0, 32'hFFFF_FFFF};

  initial begin
    int           c0;
    int           hi;
    int           cnt;
    int           bad;
    logic [W-1:0] snap;

    bus0.in_valid  = 1'b0;
    bus0.opcode    = '0;
    bus0.a         = '0;
    bus0.b         = '0;
    bus0.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_idle("reset");
    @(posedge clk);
    #1;
    reset = 1'b0;

    for (int i = 0; i < 12; i++) send(d_op[i], d_a[i], d_b[i]);
    drain();

    // MUL 7 * -3: in_ready must stay low for all WIDTH CALC cycles.
    send(OP_MUL, 32'd7, 32'hFFFF_FFFD);
    hi = 0;
    cnt = 0;
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      if (bus0.out_valid) break;
      if (bus0.in_ready) hi++;
      cnt++;
    end
    chk("mul_in_ready_calc", hi, 0);
    chk("mul_calc_cycles", cnt, W);
    @(posedge clk);
    #1;
    drain();

    for (int i = 0; i < 5; i++) send(OP_MUL, m_a[i], m_b[i]);
    drain();

    c0 = cyc;
    for (int i = 0; i < 4; i++) send(OP_ADD, 32'(100 * i), 32'(i + 1));
    chk("b2b_throughput", cyc - c0, 4);
    drain();

    bus0.out_ready = 1'b0;
    send(OP_SUB, 32'h55, 32'h99);
    @(negedge clk);
    snap = bus0.result;
    bad = 0;
    repeat (5) begin
      @(negedge clk);
      if (!bus0.out_valid || bus0.in_ready || bus0.result !== snap) bad++;
    end
    chk("stall_hold", bad, 0);
    @(posedge clk);
    #1;
    bus0.out_ready = 1'b1;
    drain();

    // Reset ten cycles into a MUL: the op vanishes and nothing is emitted.
    send(OP_MUL, 32'd123, 32'd456);
    repeat (9) @(posedge clk);
    #1;
    reset = 1'b1;
    sb.delete();
    seen = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check_idle("mul_abort");
    hi = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus0.out_valid || bus1.out_valid) hi++;
    end
    chk("mul_abort_no_out", hi, 0);

    @(posedge clk);
    #1;
    reset = 1'b1;
    bus0.in_valid = 1'b1;
    bus0.opcode = OP_ADD;
    @(posedge clk);
    #1;
    bus0.in_valid = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    chk("reset_beats_valid", bus0.out_valid, 0);

    @(posedge clk);
    #1;
    rnd_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      logic [W-1:0] ra, rb;
      ra = ($urandom_range(0, 2) == 0) ? r_vals[$urandom_range(0, 3)] : $urandom;
      rb = ($urandom_range(0, 2) == 0) ? r_vals[$urandom_range(0, 3)] : $urandom;
      send(r_ops[$urandom_range(0, 5)], ra, rb);
    end
    rnd_ready = 1'b0;
    bus0.out_ready = 1'b1;
    drain();

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

endmodule
